// File: rtl/img_pkg.sv
// Shared pixel/window types and FSM state encoding for the image filter pipeline.
// Used by the window generator and the downstream filter stage.
package img_pkg;

    localparam int PIX_W  = 8;
    localparam int KERNEL = 3;

    typedef logic [PIX_W-1:0] pixel_t;

    // Indexed [row][col]; row 0 is the oldest line, col 0 the oldest column.
    typedef pixel_t [KERNEL-1:0][KERNEL-1:0] window_t;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/window_generator_if.sv
// Pixel-in / window-out stream bundle between the raster source, the window
// generator (slave) and the filter stage.
interface window_generator_if;
    import img_pkg::*;

    pixel_t  pix_data;
    logic    pix_valid;
    logic    pix_ready;
    window_t win_data;
    logic    win_valid;
    logic    win_ready;
    logic    frame_done;

    modport master (
        output pix_data, pix_valid, win_ready,
        input  pix_ready, win_data, win_valid, frame_done
    );

    modport slave (
        input  pix_data, pix_valid, win_ready,
        output pix_ready, win_data, win_valid, frame_done
    );

endinterface

// File: rtl/line_buffer.sv
// One-line pixel delay: dout is the pixel written DEPTH enables ago; the
// delay line advances only when en is high.
module line_buffer
    import img_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en,
    input  pixel_t din,
    output pixel_t dout
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    pixel_t          mem [DEPTH];
    logic [AW-1:0]   ptr;

    assign dout = mem[ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == PTR_LAST) ? '0 : ptr + AW'(1);
        end
    end

    // NOTE: storage arrays get no reset so they map to RAM; stale contents are never observable.
    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr] <= din;
        end
    end

endmodule

// File: rtl/window_generator.sv
// Turns a raster pixel stream into 3x3 neighbourhood windows (no border
// padding) for the filter stage, with a registered valid/ready output.
module window_generator
    import img_pkg::*;
#(
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8
) (
    input logic               clk,
    input logic               rst_n,
    window_generator_if.slave bus
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          accept, line_end, frame_end, emit;
    pixel_t        tap1, tap2;
    window_t       sr, win_nxt, win_q;
    logic          win_valid_q, frame_done_q;

    assign bus.pix_ready  = !win_valid_q || bus.win_ready;
    assign bus.win_data   = win_q;
    assign bus.win_valid  = win_valid_q;
    assign bus.frame_done = frame_done_q;

    assign accept    = bus.pix_valid && bus.pix_ready;
    assign line_end  = accept && (col == COL_LAST);
    assign frame_end = line_end && (row == ROW_LAST);
    assign emit      = accept && (state == ST_RUN) && (col >= CW'(2));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            col <= line_end ? '0 : col + CW'(1);
            if (frame_end) begin
                row <= '0;
            end else if (line_end) begin
                row <= row + RW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: default assignment first keeps this combinational block latch-free.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_FILL: if (line_end && (row == RW'(1))) state_nxt = ST_RUN;
            ST_RUN:  if (frame_end)                   state_nxt = ST_FILL;
            default: state_nxt = ST_FILL;
        endcase
    end

    line_buffer #(.DEPTH(IMG_WIDTH)) u_lb_r1 (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (accept),
        .din  (bus.pix_data),
        .dout (tap1)
    );

    line_buffer #(.DEPTH(IMG_WIDTH)) u_lb_r2 (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (accept),
        .din  (tap1),
        .dout (tap2)
    );

    // Shift every row left one column and append the column for the accepted pixel.
    always_comb begin
        win_nxt = sr;
        for (int r = 0; r < KERNEL; r++) begin
            win_nxt[r][0] = sr[r][1];
            win_nxt[r][1] = sr[r][2];
        end
        win_nxt[0][2] = tap2;
        win_nxt[1][2] = tap1;
        win_nxt[2][2] = bus.pix_data;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            sr <= win_nxt;
        end
        if (emit) begin
            win_q <= win_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= frame_end;
            if (emit) begin
                win_valid_q <= 1'b1;
            end else if (bus.win_ready) begin
                win_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_window_generator.sv
// Self-checking bench: a 4x4 instance for directed frames/stall/reset and an
// 8x8 instance for random handshakes; expected windows flow through scoreboards.
module tb_window_generator;
    import img_pkg::*;

    typedef struct {
        window_t win;
        bit      last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    window_generator_if bus4 ();
    window_generator_if bus8 ();

    window_generator #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut4 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus4)
    );

    window_generator #(.IMG_WIDTH(8), .IMG_HEIGHT(8)) dut8 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus8)
    );

    exp_t   q0[$];
    exp_t   q1[$];
    pixel_t img [2][8][8];
    int     mrow[2], mcol[2];
    int     fd_exp[2], fd_seen[2], win_seen[2];
    int     rdy_mode[2];
    int     stall_cnt[2];
    int     n_checks = 0;
    int     n_errors = 0;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic int dim(input int k);
        return (k == 0) ? 4 : 8;
    endfunction

    function automatic int q_size(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t q_front(input int k);
        return (k == 0) ? q0[0] : q1[0];
    endfunction

    function automatic logic get_pr(input int k);
        return (k == 0) ? bus4.pix_ready : bus8.pix_ready;
    endfunction

    function automatic logic get_wv(input int k);
        return (k == 0) ? bus4.win_valid : bus8.win_valid;
    endfunction

    task automatic set_pix(input int k, input logic v, input pixel_t d);
        if (k == 0) begin
            bus4.pix_valid = v;
            bus4.pix_data  = d;
        end else begin
            bus8.pix_valid = v;
            bus8.pix_data  = d;
        end
    endtask

    // Reference model: remembers the frame image and builds windows from it directly.
    task automatic model_accept(input int k, input pixel_t d);
        exp_t e;
        bit   last;
        int   w;
        w = dim(k);
        img[k][mrow[k]][mcol[k]] = d;
        last = (mrow[k] == w - 1) && (mcol[k] == w - 1);
        if (mrow[k] >= 2 && mcol[k] >= 2) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    e.win[i][j] = img[k][mrow[k] - 2 + i][mcol[k] - 2 + j];
            e.last = last;
            if (k == 0) q0.push_back(e); else q1.push_back(e);
        end
        if (last) fd_exp[k]++;
        if (mcol[k] == w - 1) begin
            mcol[k] = 0;
            mrow[k] = last ? 0 : mrow[k] + 1;
        end else begin
            mcol[k]++;
        end
    endtask

    task automatic observe(input int k, input window_t wd, input logic wv, input logic wr,
                           input logic pr, input logic fd);
        exp_t e;
        if (fd) begin
            fd_seen[k]++;
            check("frame_done_with_valid", wv, 1'b1);
            if (q_size(k) > 0) begin
                e = q_front(k);
                check("frame_done_last_window", e.last, 1'b1);
            end
        end
        if (wv) begin
            check("window_expected", q_size(k) != 0, 1'b1);
            if (q_size(k) != 0) begin
                e = q_front(k);
                if (wr) begin
                    check("win_data", wd, e.win);
                    if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                    win_seen[k]++;
                end else begin
                    check("win_data_held", wd, e.win);
                    check("pix_ready_stalled", pr, 1'b0);
                end
            end
        end else begin
            check("pix_ready_idle", pr, 1'b1);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            observe(0, bus4.win_data, bus4.win_valid, bus4.win_ready, bus4.pix_ready, bus4.frame_done);
            observe(1, bus8.win_data, bus8.win_valid, bus8.win_ready, bus8.pix_ready, bus8.frame_done);
        end
    end

    function automatic logic next_ready(input int k);
        logic r;
        r = 1'b1;
        if (rdy_mode[k] == 1) begin
            r = 1'($urandom_range(0, 1));
        end else if (rdy_mode[k] == 2 && get_wv(k) && stall_cnt[k] < 5) begin
            r = 1'b0;
            stall_cnt[k]++;
        end
        return r;
    endfunction

    initial forever begin
        @(posedge clk);
        #1;
        bus4.win_ready = next_ready(0);
        bus8.win_ready = next_ready(1);
    end

    task automatic send_pixel(input int k, input pixel_t d, input bit gaps);
        bit   done;
        logic v;
        int   guard;
        done  = 1'b0;
        guard = 0;
        while (!done) begin
            v = gaps ? logic'($urandom_range(0, 2) != 0) : 1'b1;
            set_pix(k, v, d);
            @(negedge clk);
            if (v && get_pr(k)) begin
                model_accept(k, d);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            guard++;
            if (!done && guard >= 200) begin
                check("pix_accept_timeout", done, 1'b1);
                break;
            end
        end
    endtask

    task automatic send_frame(input int k, input int base, input bit gaps);
        int w;
        w = dim(k);
        for (int i = 0; i < w * w; i++) send_pixel(k, pixel_t'(base + i), gaps);
        set_pix(k, 1'b0, '0);
    endtask

    task automatic drain(input int k);
        int n;
        n = 0;
        while ((q_size(k) != 0 || get_wv(k)) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_queue_empty", q_size(k), 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_pix_ready_4", bus4.pix_ready, 1'b1);
        check("rst_win_valid_4", bus4.win_valid, 1'b0);
        check("rst_frame_done_4", bus4.frame_done, 1'b0);
        check("rst_pix_ready_8", bus8.pix_ready, 1'b1);
        check("rst_win_valid_8", bus8.win_valid, 1'b0);
        check("rst_frame_done_8", bus8.frame_done, 1'b0);
    endtask

    initial begin
        set_pix(0, 1'b0, '0);
        set_pix(1, 1'b0, '0);
        bus4.win_ready = 1'b1;
        bus8.win_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            mrow[k] = 0; mcol[k] = 0; fd_exp[k] = 0; fd_seen[k] = 0;
            win_seen[k] = 0; rdy_mode[k] = 0; stall_cnt[k] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;
        #1;
        check_reset_outputs();

        // Basic 4x4 frame with an always-ready consumer.
        send_frame(0, 0, 1'b0);
        drain(0);

        // Same frame with the first window stalled for five cycles.
        rdy_mode[0] = 2;
        send_frame(0, 0, 1'b0);
        drain(0);
        check("stall_cycles", stall_cnt[0], 5);
        rdy_mode[0] = 0;

        // Two frames back to back.
        send_frame(0, 0, 1'b0);
        send_frame(0, 100, 1'b0);
        drain(0);

        // Partial frame aborted by reset, then a clean frame.
        for (int i = 0; i < 10; i++) send_pixel(0, pixel_t'(i), 1'b0);
        set_pix(0, 1'b0, '0);
        @(posedge clk);
        #1;
        check("no_window_before_reset", q_size(0), 0);
        rst_n = 1'b0;
        mrow[0] = 0; mcol[0] = 0;
        repeat (2) @(posedge clk);
        #1;
        check("in_reset_win_valid_4", bus4.win_valid, 1'b0);
        rst_n = 1'b1;
        #1;
        check_reset_outputs();
        send_frame(0, 0, 1'b0);
        drain(0);

        // 8x8 frame with random source gaps and random back-pressure.
        rdy_mode[1] = 1;
        send_frame(1, 0, 1'b1);
        rdy_mode[1] = 0;
        drain(1);

        check("windows_4x4_total", win_seen[0], 20);
        check("windows_8x8_total", win_seen[1], 36);
        check("frame_done_count_4", fd_seen[0], fd_exp[0]);
        check("frame_done_count_8", fd_seen[1], fd_exp[1]);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
